// File: rtl/spis_dma_read_fifo_if.sv
// Signal bundle between the SPI-slave DMA read prefetch FIFO, its host/consumer and the memory arbiter.
// The master side drives control, consumer pops and arbiter returns; the slave side is the FIFO block.
interface spis_dma_read_fifo_if #(
   parameter int FIFO_WORDS = 64
);
   localparam int LW = $clog2(FIFO_WORDS);

   logic          start;
   logic [31:0]   dma_addr;
   logic [15:0]   word_count;
   logic          rd_strobe;
   logic [31:0]   rd_data;
   logic          rd_valid;
   logic          qpimem_arb_do_read;
   logic          qpimem_arb_next_word;
   logic [31:0]   qpimem_arb_addr;
   logic [31:0]   qpimem_arb_rdata;
   logic [LW-1:0] level;
   logic          full;
   logic          empty;
   logic          done;
   logic          underflow;

   modport master (
      output start, dma_addr, word_count, rd_strobe,
      output qpimem_arb_next_word, qpimem_arb_rdata,
      input  rd_data, rd_valid, qpimem_arb_do_read, qpimem_arb_addr,
      input  level, full, empty, done, underflow
   );

   modport slave (
      input  start, dma_addr, word_count, rd_strobe,
      input  qpimem_arb_next_word, qpimem_arb_rdata,
      output rd_data, rd_valid, qpimem_arb_do_read, qpimem_arb_addr,
      output level, full, empty, done, underflow
   );
endinterface

// File: rtl/spis_dma_read_fifo.sv
// Prefetch FIFO feeding the SPI-slave MISO shifter: fetches word_count words from memory in
// bursts through the qpimem arbiter and presents them first-word fall-through to the consumer.
module spis_dma_read_fifo #(
   parameter int FIFO_WORDS  = 64,
   parameter int BURST_WORDS = 32
) (
   input  logic                clk,
   input  logic                reset,
   spis_dma_read_fifo_if.slave bus
);
   localparam int AW = $clog2(FIFO_WORDS);
   localparam int CW = 17;
   localparam logic [CW-1:0] BURST_C  = CW'(BURST_WORDS);
   localparam logic [CW-1:0] USABLE_C = CW'(FIFO_WORDS - 1);
   localparam logic [AW-1:0] FULL_LVL = AW'(FIFO_WORDS - 1);

   typedef enum logic [1:0] {IDLE, WAIT_SPACE, BURST, DONE} state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] w_ptr_q, w_ptr_d;
   logic [AW-1:0] r_ptr_q, r_ptr_d;
   logic [31:0]   addr_q, addr_d;
   logic [15:0]   remaining_q, remaining_d;
   logic [CW-1:0] burst_cnt_q, burst_cnt_d;
   logic          do_read_q, do_read_d;
   logic          underflow_q, underflow_d;
   logic [31:0]   rd_data_q;
   logic [31:0]   ram [FIFO_WORDS];

   logic [AW-1:0] level;
   logic          empty;
   logic          push;
   logic          pop;
   logic [CW-1:0] rem_ext;
   logic [CW-1:0] blen;
   logic [CW-1:0] free_words;

   assign level      = w_ptr_q - r_ptr_q;
   assign empty      = (level == '0);
   assign push       = (state_q == BURST) && bus.qpimem_arb_next_word && !bus.start;
   assign pop        = bus.rd_strobe && !empty && !bus.start;
   assign rem_ext    = {1'b0, remaining_q};
   assign blen       = (rem_ext > BURST_C) ? BURST_C : rem_ext;
   assign free_words = USABLE_C - {{(CW-AW){1'b0}}, level};

   always_comb begin
      state_d     = state_q;
      w_ptr_d     = w_ptr_q;
      r_ptr_d     = r_ptr_q;
      addr_d      = addr_q;
      remaining_d = remaining_q;
      burst_cnt_d = burst_cnt_q;
      do_read_d   = do_read_q;
      underflow_d = underflow_q;

      if (bus.start) begin
         w_ptr_d     = '0;
         r_ptr_d     = '0;
         underflow_d = 1'b0;
         addr_d      = bus.dma_addr;
         remaining_d = bus.word_count;
         burst_cnt_d = '0;
         do_read_d   = 1'b0;
         state_d     = (bus.word_count == 16'd0) ? DONE : WAIT_SPACE;
      end else begin
         if (pop) begin
            r_ptr_d = r_ptr_q + 1'b1;
         end else if (bus.rd_strobe) begin
            underflow_d = 1'b1;
         end

         unique case (state_q)
            WAIT_SPACE: begin
               // Space is judged only here; pops during a burst can only add room.
               if (remaining_q == 16'd0) begin
                  state_d = DONE;
               end else if (free_words >= blen) begin
                  state_d     = BURST;
                  burst_cnt_d = blen;
                  do_read_d   = 1'b1;
               end
            end
            BURST: begin
               if (push) begin
                  w_ptr_d     = w_ptr_q + 1'b1;
                  addr_d      = addr_q + 32'd4;
                  remaining_d = remaining_q - 16'd1;
                  burst_cnt_d = burst_cnt_q - CW'(1);
                  if (burst_cnt_q == CW'(1)) begin
                     do_read_d = 1'b0;
                     state_d   = WAIT_SPACE;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         w_ptr_q     <= '0;
         r_ptr_q     <= '0;
         addr_q      <= '0;
         remaining_q <= '0;
         burst_cnt_q <= '0;
         do_read_q   <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         w_ptr_q     <= w_ptr_d;
         r_ptr_q     <= r_ptr_d;
         addr_q      <= addr_d;
         remaining_q <= remaining_d;
         burst_cnt_q <= burst_cnt_d;
         do_read_q   <= do_read_d;
         underflow_q <= underflow_d;
      end
   end

   // Registered read addressed by the next read pointer gives fall-through timing; a word
   // written into the slot about to become the head is forwarded straight into the output register.
   always_ff @(posedge clk) begin
      if (push && !reset) begin
         ram[w_ptr_q] <= bus.qpimem_arb_rdata;
      end
      if (push && !reset && (w_ptr_q == r_ptr_d)) begin
         rd_data_q <= bus.qpimem_arb_rdata;
      end else begin
         rd_data_q <= ram[r_ptr_d];
      end
   end

   assign bus.rd_data            = rd_data_q;
   assign bus.rd_valid           = !empty;
   assign bus.qpimem_arb_do_read = do_read_q;
   assign bus.qpimem_arb_addr    = addr_q;
   assign bus.level              = level;
   assign bus.full               = (level == FULL_LVL);
   assign bus.empty              = empty;
   assign bus.done               = (state_q == DONE);
   assign bus.underflow          = underflow_q;
endmodule

// File: tb/tb_spis_dma_read_fifo.sv
// Randomized bench for spis_dma_read_fifo: plays arbiter and consumer, checks every cycle
// against a queue-based model of the fetch and the burst rules.
module tb_spis_dma_read_fifo;
   localparam int FW = 64;
   localparam int BW = 32;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   spis_dma_read_fifo_if #(.FIFO_WORDS(FW)) bus ();

   spis_dma_read_fifo #(.FIFO_WORDS(FW), .BURST_WORDS(BW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // reference model
   logic [31:0] q_m[$];
   logic [31:0] addr_m;
   int          rem_m;
   bit          active_m, done_m, uf_m, just_cleared;
   bit          prev_dr;
   int          prev_level, burst_words, burst_expect, stall_cnt;
   bit          seq_mode;
   logic [31:0] seq_data;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   // One clock: check outputs against the model, drive inputs, advance model at the edge.
   task automatic cycle(input bit st, input logic [31:0] a, input int wc, input int nw_pct,
                        input int pop_pct, input int stray_pct, input bit rst);
      bit          dr, nw, pp;
      int          blen;
      logic [31:0] wdata;
      dr = bus.qpimem_arb_do_read;
      check_val("level", 32'(bus.level), 32'(q_m.size()));
      check_val("empty", 32'(bus.empty), 32'(q_m.size() == 0));
      check_val("full", 32'(bus.full), 32'(q_m.size() == FW-1));
      check_val("rd_valid", 32'(bus.rd_valid), 32'(q_m.size() != 0));
      if (q_m.size() != 0) check_val("rd_data", bus.rd_data, q_m[0]);
      check_val("arb_addr", bus.qpimem_arb_addr, addr_m);
      check_val("done", 32'(bus.done), 32'(done_m));
      check_val("underflow", 32'(bus.underflow), 32'(uf_m));
      if (just_cleared) check_val("dr_after_clear", 32'(dr), 0);
      if (dr) check_val("dr_needs_rem", 32'(rem_m > 0), 1);
      blen = (rem_m < BW) ? rem_m : BW;
      if (dr && !prev_dr) begin
         check_val("dr_rise_space", 32'((FW-1-prev_level) >= blen), 1);
         burst_expect = blen;
         burst_words  = 0;
      end
      if (!dr && prev_dr && !just_cleared) check_val("burst_len", burst_words, burst_expect);
      if (!dr && active_m && rem_m > 0 && (FW-1-q_m.size()) >= blen) stall_cnt++;
      else stall_cnt = 0;
      check_val("dr_live", 32'(stall_cnt > 2), 0);

      nw    = dr ? ($urandom_range(99) < nw_pct) : ($urandom_range(99) < stray_pct);
      pp    = ($urandom_range(99) < pop_pct);
      wdata = seq_mode ? seq_data : $urandom();
      bus.start                = st;
      bus.dma_addr             = a;
      bus.word_count           = wc[15:0];
      bus.rd_strobe            = pp;
      bus.qpimem_arb_next_word = nw;
      bus.qpimem_arb_rdata     = wdata;
      reset                    = rst;
      prev_dr                  = dr;
      prev_level               = q_m.size();
      @(posedge clk);
      if (rst) begin
         q_m.delete(); addr_m = 0; rem_m = 0; active_m = 0; done_m = 0; uf_m = 0;
         just_cleared = 1; stall_cnt = 0;
      end else if (st) begin
         q_m.delete(); addr_m = a; rem_m = wc; active_m = (wc != 0); done_m = (wc == 0);
         uf_m = 0; just_cleared = 1; stall_cnt = 0;
      end else begin
         just_cleared = 0;
         if (active_m && rem_m == 0) done_m = 1;
         if (pp) begin
            if (q_m.size() != 0) void'(q_m.pop_front());
            else uf_m = 1;
         end
         if (nw && dr) begin
            q_m.push_back(wdata);
            addr_m = addr_m + 32'd4;
            rem_m--;
            burst_words++;
            if (seq_mode) seq_data = seq_data + 32'd1;
         end
      end
      @(negedge clk);
   endtask

   task automatic run_until_done(input int nw_pct, input int pop_pct);
      int k = 0;
      while (!done_m && k < 4000) begin
         cycle(0, 0, 0, nw_pct, pop_pct, 5, 0);
         k++;
      end
      check_val("fetch_done", 32'(bus.done), 1);
   endtask

   task automatic drain();
      int k = 0;
      while (q_m.size() != 0 && k < 400) begin
         cycle(0, 0, 0, 0, 100, 5, 0);
         k++;
      end
      check_val("drained", 32'(bus.empty), 1);
   endtask

   initial begin
      reset = 1'b1;
      bus.start = 0; bus.dma_addr = 0; bus.word_count = 0; bus.rd_strobe = 0;
      bus.qpimem_arb_next_word = 0; bus.qpimem_arb_rdata = 0;
      q_m.delete(); addr_m = 0; rem_m = 0; active_m = 0; done_m = 0; uf_m = 0;
      just_cleared = 1; prev_dr = 0; prev_level = 0; burst_words = 0; burst_expect = 0;
      stall_cnt = 0; seq_mode = 0; seq_data = 0;
      @(negedge clk);
      cycle(0, 0, 0, 0, 50, 50, 1);
      check_val("rst_do_read", 32'(bus.qpimem_arb_do_read), 0);
      check_val("rst_empty", 32'(bus.empty), 1);

      // 8-word fetch with sequential data, latency and ordering
      seq_mode = 1; seq_data = 32'hA0;
      cycle(1, 32'h1000, 8, 100, 0, 0, 0);
      check_val("lat_dr_low", 32'(bus.qpimem_arb_do_read), 0);
      cycle(0, 0, 0, 100, 0, 0, 0);
      check_val("lat_dr_high", 32'(bus.qpimem_arb_do_read), 1);
      check_val("lat_addr0", bus.qpimem_arb_addr, 32'h1000);
      cycle(0, 0, 0, 100, 0, 0, 0);
      check_val("lat_valid", 32'(bus.rd_valid), 1);
      check_val("first_word", bus.rd_data, 32'hA0);
      run_until_done(100, 0);
      check_val("end_addr8", bus.qpimem_arb_addr, 32'h1020);
      check_val("level8", 32'(bus.level), 8);
      drain();
      seq_mode = 0;

      // zero-length fetch, then underflow and its clearing
      cycle(1, 32'h3000, 0, 100, 0, 0, 0);
      check_val("wc0_done", 32'(bus.done), 1);
      repeat (4) cycle(0, 0, 0, 100, 100, 20, 0);
      check_val("uf_set", 32'(bus.underflow), 1);
      check_val("uf_level", 32'(bus.level), 0);
      cycle(1, 32'h3000, 0, 100, 0, 0, 0);
      check_val("uf_cleared", 32'(bus.underflow), 0);

      // 100 words, no pops: stalls when the next 32-word burst no longer fits
      cycle(1, 32'h4000, 100, 100, 0, 0, 0);
      repeat (60) cycle(0, 0, 0, 100, 0, 10, 0);
      check_val("stall_level", 32'(bus.level), BW);
      check_val("stall_dr", 32'(bus.qpimem_arb_do_read), 0);
      run_until_done(80, 70);
      check_val("addr_400", bus.qpimem_arb_addr, 32'h4000 + 32'd400);
      drain();

      // restart mid-burst, stray next_word while waiting
      cycle(1, 32'h5000, 50, 100, 0, 0, 0);
      repeat (8) cycle(0, 0, 0, 100, 0, 0, 0);
      cycle(1, 32'h2000, 20, 100, 0, 0, 0);
      check_val("rs_dr_low", 32'(bus.qpimem_arb_do_read), 0);
      check_val("rs_level", 32'(bus.level), 0);
      cycle(0, 0, 0, 100, 0, 100, 0);
      check_val("stray_addr", bus.qpimem_arb_addr, 32'h2000);
      run_until_done(90, 40);
      drain();

      // reset mid-burst
      cycle(1, 32'h6000, 40, 100, 0, 0, 0);
      repeat (6) cycle(0, 0, 0, 100, 0, 0, 0);
      cycle(0, 0, 0, 100, 0, 0, 1);
      check_val("rr_dr_low", 32'(bus.qpimem_arb_do_read), 0);
      check_val("rr_addr", bus.qpimem_arb_addr, 0);

      // randomized fetches: long runs wrap pointers, some runs wrap the address
      for (int it = 0; it < 8; it++) begin
         logic [31:0] a;
         int wc;
         a  = (it % 3 == 0) ? 32'hFFFF_FF80 : ($urandom() & 32'hFFFF_FFFC);
         wc = (it < 2) ? 150 + it * 30 : $urandom_range(0, 200);
         cycle(1, a, wc, 100, 0, 0, 0);
         if (it == 5) begin
            repeat (15) cycle(0, 0, 0, 70, 60, 5, 0);
            cycle(1, a + 32'h100, wc, 100, 0, 0, 0);
         end
         run_until_done($urandom_range(30, 100), $urandom_range(20, 90));
         drain();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
